xadc_drp_multi_channel_sequencer: RTL and testbench

XADC_DRP_MULTI_CHANNEL_SEQUENCER -- requirements
Module: xadc_drp_multi_channel_sequencer

---
 rtl/xadc_drp_multi_channel_sequencer_pkg.sv | 13 +
 rtl/xadc_drp_multi_channel_sequencer_axis_sample_hold_reg.sv | 30 +++
 rtl/xadc_drp_multi_channel_sequencer.sv | 125 ++++++++++++
 tb/tb_xadc_drp_multi_channel_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/xadc_drp_multi_channel_sequencer_pkg.sv
// Shared XADC DRP constants and the sequencer state encoding.
package teachee_defs;

  localparam logic [6:0] XADC_ADDR_CURRENT = 7'h14;
  localparam logic [6:0] XADC_ADDR_VOLTAGE = 7'h1c;

  typedef enum logic [1:0] {
    AWAIT_EOS,
    ISSUE,
    WAIT_DRDY
  } seq_state_t;

endpackage

// File: rtl/xadc_drp_multi_channel_sequencer_axis_sample_hold_reg.sv
// Single-channel AXIS holding register; flags a sample lost to overwrite.
module axis_sample_hold_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        tready,
  output logic [15:0] tdata,
  output logic        tvalid,
  output logic        overflow_pulse
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata          <= '0;
      tvalid         <= 1'b0;
      overflow_pulse <= 1'b0;
    end else begin
      // A load coinciding with an accept is not a loss: the old beat was taken.
      overflow_pulse <= load & tvalid & ~tready;
      if (load) begin
        tdata  <= load_data;
        tvalid <= 1'b1;
      end else if (tvalid && tready) begin
        tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_multi_channel_sequencer.sv
// Reads a list of XADC DRP channels on every end-of-sequence and presents
// each result on its own AXIS-style holding register.
module xadc_drp_multi_channel_sequencer
  import teachee_defs::*;
#(
  parameter int unsigned                   NUM_CHANNELS  = 2,
  parameter logic [7*NUM_CHANNELS-1:0]     CHANNEL_ADDRS = {XADC_ADDR_VOLTAGE, XADC_ADDR_CURRENT},
  parameter int unsigned                   DRDY_TIMEOUT  = 64,
  parameter bit                            JUSTIFY_12    = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clear_errors,
  input  logic                       eos,
  output logic [6:0]                 drp_daddr,
  output logic                       drp_den,
  output logic                       drp_dwe,
  output logic [15:0]                drp_di,
  input  logic                       drp_drdy,
  input  logic [15:0]                drp_do,
  output logic [16*NUM_CHANNELS-1:0] m_tdata,
  output logic [NUM_CHANNELS-1:0]    m_tvalid,
  input  logic [NUM_CHANNELS-1:0]    m_tready,
  output logic [NUM_CHANNELS-1:0]    overflow_pulse,
  output logic                       timeout_error,
  output logic                       sweep_overrun,
  output logic                       busy
);

  localparam int unsigned IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned TW = $clog2(DRDY_TIMEOUT);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRDY_TIMEOUT - 1);

  seq_state_t state, next_state;
  logic [IW-1:0] idx, next_idx;
  logic [TW-1:0] tcnt, next_tcnt;
  logic capture, timeout_hit;
  logic [15:0] sample;
  logic [NUM_CHANNELS-1:0] load;

  always_comb begin
    next_state  = state;
    next_idx    = idx;
    next_tcnt   = tcnt;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      AWAIT_EOS: begin
        if (eos && enable) begin
          next_state = ISSUE;
          next_idx   = '0;
        end
      end
      ISSUE: begin
        next_tcnt  = '0;
        next_state = WAIT_DRDY;
      end
      WAIT_DRDY: begin
        // drdy on the final count still counts as a capture.
        if (drp_drdy) capture = 1'b1;
        else if (tcnt == TMO_LAST) timeout_hit = 1'b1;
        else next_tcnt = tcnt + 1'b1;
        if (capture || timeout_hit) begin
          if (idx == LAST_IDX) begin
            next_state = AWAIT_EOS;
          end else begin
            next_idx   = idx + 1'b1;
            next_state = ISSUE;
          end
        end
      end
      default: next_state = AWAIT_EOS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= AWAIT_EOS;
      idx           <= '0;
      tcnt          <= '0;
      timeout_error <= 1'b0;
      sweep_overrun <= 1'b0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      tcnt  <= next_tcnt;
      if (timeout_hit) timeout_error <= 1'b1;
      else if (clear_errors) timeout_error <= 1'b0;
      if (eos && state != AWAIT_EOS) sweep_overrun <= 1'b1;
      else if (clear_errors) sweep_overrun <= 1'b0;
    end
  end

  // idx only moves on entry to ISSUE, so the address holds between reads.
  always_comb begin
    drp_daddr = CHANNEL_ADDRS[6:0];
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (idx == IW'(i)) drp_daddr = CHANNEL_ADDRS[7*i +: 7];
    end
  end

  assign drp_den = (state == ISSUE);
  assign drp_dwe = 1'b0;
  assign drp_di  = '0;
  assign busy    = (state != AWAIT_EOS);
  assign sample  = JUSTIFY_12 ? {4'b0000, drp_do[15:4]} : drp_do;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    assign load[i] = capture && (idx == IW'(i));

    axis_sample_hold_reg u_hold (
      .clk            (clk),
      .rst            (rst),
      .load           (load[i]),
      .load_data      (sample),
      .tready         (m_tready[i]),
      .tdata          (m_tdata[16*i +: 16]),
      .tvalid         (m_tvalid[i]),
      .overflow_pulse (overflow_pulse[i])
    );
  end

endmodule

// File: tb/tb_xadc_drp_multi_channel_sequencer.sv
// Directed bench: a 3-cycle-latency DRP responder feeds a raw and a 12-bit
// justified sequencer; per-feature tasks check against hand-computed values.
module tb_xadc_drp_multi_channel_sequencer;

  logic clk = 1'b0;
  logic rst, enable, clear_errors, eos, drp_drdy;
  logic [15:0] drp_do;
  logic [1:0]  m_tready;

  logic [6:0]  drp_daddr, j_drp_daddr;
  logic        drp_den, j_drp_den, drp_dwe, j_drp_dwe;
  logic [15:0] drp_di, j_drp_di;
  logic [31:0] m_tdata, j_m_tdata;
  logic [1:0]  m_tvalid, j_m_tvalid, overflow_pulse, j_overflow_pulse;
  logic        timeout_error, j_timeout_error, sweep_overrun, j_sweep_overrun;
  logic        busy, j_busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  xadc_drp_multi_channel_sequencer #(.DRDY_TIMEOUT(8), .JUSTIFY_12(1'b0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear_errors(clear_errors), .eos(eos),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_drdy(drp_drdy), .drp_do(drp_do), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .overflow_pulse(overflow_pulse), .timeout_error(timeout_error),
    .sweep_overrun(sweep_overrun), .busy(busy)
  );

  xadc_drp_multi_channel_sequencer #(.DRDY_TIMEOUT(8), .JUSTIFY_12(1'b1)) dut_j (
    .clk(clk), .rst(rst), .enable(enable), .clear_errors(clear_errors), .eos(eos),
    .drp_daddr(j_drp_daddr), .drp_den(j_drp_den), .drp_dwe(j_drp_dwe), .drp_di(j_drp_di),
    .drp_drdy(drp_drdy), .drp_do(drp_do), .m_tdata(j_m_tdata), .m_tvalid(j_m_tvalid),
    .m_tready(m_tready), .overflow_pulse(j_overflow_pulse), .timeout_error(j_timeout_error),
    .sweep_overrun(j_sweep_overrun), .busy(j_busy)
  );

  // DRP responder: answers a den seen in cycle C with drdy in cycle C+3.
  logic [15:0] ch0_data, ch1_data, drp_pend;
  bit skip_ch0;
  int drp_cnt = 0;
  always begin
    @(posedge clk); #1;
    drp_drdy = 1'b0;
    if (drp_cnt > 0) begin
      drp_cnt--;
      if (drp_cnt == 0) begin drp_drdy = 1'b1; drp_do = drp_pend; end
    end
    if (drp_den && !(skip_ch0 && drp_daddr == 7'h14)) begin
      drp_cnt  = 3;
      drp_pend = (drp_daddr == 7'h14) ? ch0_data : ch1_data;
    end
  end

  int den_cnt = 0;
  logic [6:0] den_log [64];
  int beats [2] = '{0, 0};
  int ovf_cnt [2] = '{0, 0};
  logic [15:0] beat_data [2] = '{16'h0, 16'h0};
  logic [15:0] jbeat_data [2] = '{16'h0, 16'h0};
  always @(negedge clk) begin
    if (drp_den === 1'b1) begin
      if (den_cnt < 64) den_log[den_cnt] = drp_daddr;
      den_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      if (m_tvalid[i] && m_tready[i]) begin beats[i]++; beat_data[i] = m_tdata[16*i +: 16]; end
      if (j_m_tvalid[i] && m_tready[i]) jbeat_data[i] = j_m_tdata[16*i +: 16];
      if (overflow_pulse[i]) ovf_cnt[i]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_eos();
    eos = 1'b1;
    tick(1);
    eos = 1'b0;
  endtask

  task automatic test_reset();
    tick(2);
    vectors++; if ({drp_den, busy, timeout_error, sweep_overrun, m_tvalid, overflow_pulse} !== 8'h00) begin
      miscompares++; $display("FAIL reset_flags got=%b exp=0", {drp_den, busy, timeout_error, sweep_overrun, m_tvalid, overflow_pulse}); end
    vectors++; if (drp_daddr !== 7'h14) begin miscompares++; $display("FAIL reset_daddr got=%h exp=14", drp_daddr); end
    vectors++; if (m_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    vectors++; if ({drp_dwe, drp_di} !== 17'h0) begin miscompares++; $display("FAIL reset_write_ties got=%h exp=0", {drp_dwe, drp_di}); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_sweep();
    int d0, b0, b1;
    enable = 1'b1; m_tready = 2'b11; ch0_data = 16'h1230; ch1_data = 16'h4560;
    d0 = den_cnt; b0 = beats[0]; b1 = beats[1];
    pulse_eos();
    vectors++; if ({drp_den, drp_daddr} !== {1'b1, 7'h14}) begin
      miscompares++; $display("FAIL sweep_latency got=%b/%h exp=1/14", drp_den, drp_daddr); end
    tick(15);
    vectors++; if (den_cnt - d0 !== 2) begin miscompares++; $display("FAIL sweep_den_count got=%0d exp=2", den_cnt - d0); end
    vectors++; if (den_log[d0] !== 7'h14 || den_log[d0+1] !== 7'h1c) begin
      miscompares++; $display("FAIL sweep_addr_order got=%h,%h exp=14,1c", den_log[d0], den_log[d0+1]); end
    vectors++; if (beats[0] - b0 !== 1 || beats[1] - b1 !== 1) begin
      miscompares++; $display("FAIL sweep_beats got=%0d,%0d exp=1,1", beats[0] - b0, beats[1] - b1); end
    vectors++; if (beat_data[0] !== 16'h1230) begin miscompares++; $display("FAIL sweep_ch0_data got=%h exp=1230", beat_data[0]); end
    vectors++; if (beat_data[1] !== 16'h4560) begin miscompares++; $display("FAIL sweep_ch1_data got=%h exp=4560", beat_data[1]); end
    vectors++; if (jbeat_data[0] !== 16'h0123) begin miscompares++; $display("FAIL justify_ch0_data got=%h exp=0123", jbeat_data[0]); end
    vectors++; if (jbeat_data[1] !== 16'h0456) begin miscompares++; $display("FAIL justify_ch1_data got=%h exp=0456", jbeat_data[1]); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sweep_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int o0, o1, b0;
    m_tready = 2'b10; ch0_data = 16'h1000;
    o0 = ovf_cnt[0]; o1 = ovf_cnt[1]; b0 = beats[0];
    pulse_eos(); tick(15);
    ch0_data = 16'h2000;
    pulse_eos(); tick(15);
    vectors++; if (ovf_cnt[0] - o0 !== 1) begin miscompares++; $display("FAIL ovf_ch0_pulses got=%0d exp=1", ovf_cnt[0] - o0); end
    vectors++; if (ovf_cnt[1] - o1 !== 0) begin miscompares++; $display("FAIL ovf_ch1_pulses got=%0d exp=0", ovf_cnt[1] - o1); end
    vectors++; if ({m_tvalid[0], m_tdata[15:0]} !== {1'b1, 16'h2000}) begin
      miscompares++; $display("FAIL ovf_ch0_hold got=%b/%h exp=1/2000", m_tvalid[0], m_tdata[15:0]); end
    vectors++; if (beats[0] - b0 !== 0) begin miscompares++; $display("FAIL ovf_no_beat got=%0d exp=0", beats[0] - b0); end
    m_tready = 2'b11;
    tick(2);
    vectors++; if (beats[0] - b0 !== 1 || beat_data[0] !== 16'h2000 || m_tvalid !== 2'b00) begin
      miscompares++; $display("FAIL ovf_drain got=%0d/%h/%b exp=1/2000/00", beats[0] - b0, beat_data[0], m_tvalid); end
  endtask

  task automatic test_timeout();
    int b0, b1;
    skip_ch0 = 1'b1; b0 = beats[0]; b1 = beats[1];
    pulse_eos();
    // Now in the ISSUE cycle; the 8th wait cycle trips, so the flag shows after edge 9.
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      vectors++; if (timeout_error !== (k == 9)) begin
        miscompares++; $display("FAIL timeout_flag_k%0d got=%b exp=%b", k, timeout_error, k == 9); end
    end
    vectors++; if ({drp_den, drp_daddr} !== {1'b1, 7'h1c}) begin
      miscompares++; $display("FAIL timeout_next_issue got=%b/%h exp=1/1c", drp_den, drp_daddr); end
    tick(12);
    vectors++; if (beats[0] - b0 !== 0 || beats[1] - b1 !== 1) begin
      miscompares++; $display("FAIL timeout_beats got=%0d,%0d exp=0,1", beats[0] - b0, beats[1] - b1); end
    skip_ch0 = 1'b0;
  endtask

  task automatic test_overrun();
    int d0;
    d0 = den_cnt;
    pulse_eos(); tick(2);
    pulse_eos(); tick(15);
    vectors++; if (sweep_overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got=%b exp=1", sweep_overrun); end
    vectors++; if (den_cnt - d0 !== 2) begin miscompares++; $display("FAIL overrun_den_count got=%0d exp=2", den_cnt - d0); end
    clear_errors = 1'b1; tick(1); clear_errors = 1'b0;
    vectors++; if ({sweep_overrun, timeout_error} !== 2'b00) begin
      miscompares++; $display("FAIL clear_errors got=%b exp=00", {sweep_overrun, timeout_error}); end
    pulse_eos(); tick(2);
    eos = 1'b1; clear_errors = 1'b1; tick(1); eos = 1'b0; clear_errors = 1'b0;
    vectors++; if (sweep_overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set_wins got=%b exp=1", sweep_overrun); end
    tick(15);
    clear_errors = 1'b1; tick(1); clear_errors = 1'b0;
  endtask

  task automatic test_enable();
    int d0;
    enable = 1'b0; d0 = den_cnt;
    pulse_eos();
    vectors++; if ({busy, drp_den} !== 2'b00) begin miscompares++; $display("FAIL disabled_eos got=%b exp=00", {busy, drp_den}); end
    tick(5);
    enable = 1'b1;
    pulse_eos();
    enable = 1'b0;
    tick(15);
    vectors++; if (den_cnt - d0 !== 2 || busy !== 1'b0) begin
      miscompares++; $display("FAIL enable_drop_mid_sweep got=%0d/%b exp=2/0", den_cnt - d0, busy); end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int d0;
    m_tready = 2'b00;
    pulse_eos(); tick(15);
    vectors++; if (m_tvalid !== 2'b11) begin miscompares++; $display("FAIL prereset_valid got=%b exp=11", m_tvalid); end
    pulse_eos(); tick(1);
    #2 rst = 1'b1;
    #1;
    vectors++; if ({m_tvalid, m_tdata, busy, drp_den, drp_daddr} !== {2'b00, 32'h0, 1'b0, 1'b0, 7'h14}) begin
      miscompares++; $display("FAIL async_reset got=%b/%h/%b/%b/%h exp=00/0/0/0/14", m_tvalid, m_tdata, busy, drp_den, drp_daddr); end
    @(posedge clk); #1;
    rst = 1'b0; d0 = den_cnt;
    tick(10);
    vectors++; if ({m_tvalid, busy} !== 3'b000 || den_cnt - d0 !== 0) begin
      miscompares++; $display("FAIL late_drdy_ignored got=%b/%b/%0d exp=00/0/0", m_tvalid, busy, den_cnt - d0); end
    m_tready = 2'b11;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear_errors = 1'b0; eos = 1'b0; m_tready = 2'b11;
    drp_drdy = 1'b0; drp_do = 16'h0; ch0_data = 16'h0; ch1_data = 16'h0; skip_ch0 = 1'b0;
    #1;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_timeout();
    test_overrun();
    test_enable();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
